// File: rtl/z80_mem_bridge.sv
// Z80 memory-side bus responder: decodes CPU memory cycles, applies the Sega-style slot
// mapper and turns each access into one req/ack transaction on a backing-memory port.
module z80_mem_bridge #(
  parameter int ROM_BANK_W = 8,
  parameter int MEM_AW     = 22
) (
  input  logic              z80_clk,
  input  logic              z80_rst,
  input  logic [15:0]       z80_addr,
  input  logic [7:0]        z80_do,
  input  logic              z80_mreq_n,
  input  logic              z80_rd_n,
  input  logic              z80_wr_n,
  output logic [7:0]        z80_di,
  output logic              z80_di_en,
  output logic              z80_wait_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_sel,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  localparam logic [1:0] SEL_ROM  = 2'd0;
  localparam logic [1:0] SEL_SYS  = 2'd1;
  localparam logic [1:0] SEL_CART = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic                    cart_en_q;
  logic [ROM_BANK_W-1:0]   bank0_q, bank1_q, bank2_q;
  logic                    we_q;
  logic [1:0]              sel_q;
  logic [MEM_AW-1:0]       addr_q;
  logic [7:0]              wdata_q;
  logic [7:0]              di_q;

  logic                    acc;
  logic                    is_wr;
  logic                    accept;
  logic                    reg_hit;
  logic [1:0]              map_sel;
  logic [MEM_AW-1:0]       map_addr;

  // Refresh cycles assert mreq without a strobe and are not accesses.
  assign acc     = !z80_mreq_n && (!z80_rd_n || !z80_wr_n);
  assign is_wr   = z80_rd_n;
  assign accept  = (state_q == S_IDLE) && acc;
  assign reg_hit = (z80_addr[15:2] == 14'h3FFF);

  // Slot mapper; the first 1 KB is pinned to ROM bank 0 so the vectors never move.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    map_sel  = SEL_ROM;
    map_addr = '0;
    unique case (z80_addr[15:14])
      2'b00: begin
        if (z80_addr[13:10] == 4'h0) map_addr = MEM_AW'(z80_addr[13:0]);
        else                         map_addr = MEM_AW'({bank0_q, z80_addr[13:0]});
      end
      2'b01: map_addr = MEM_AW'({bank1_q, z80_addr[13:0]});
      2'b10: begin
        if (cart_en_q) begin
          map_sel  = SEL_CART;
          map_addr = MEM_AW'(z80_addr[13:0]);
        end else begin
          map_addr = MEM_AW'({bank2_q, z80_addr[13:0]});
        end
      end
      default: begin
        map_sel  = SEL_SYS;
        map_addr = MEM_AW'(z80_addr[12:0]);
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (acc) state_d = (is_wr && map_sel == SEL_ROM) ? S_DONE : S_REQ;
      S_REQ:  if (mem_ack) state_d = S_DONE;
      S_DONE: if (!acc) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge z80_clk) begin
    if (z80_rst) begin
      state_q   <= S_IDLE;
      cart_en_q <= 1'b0;
      bank0_q   <= ROM_BANK_W'(0);
      bank1_q   <= ROM_BANK_W'(1);
      bank2_q   <= ROM_BANK_W'(2);
      we_q      <= 1'b0;
      sel_q     <= SEL_ROM;
      addr_q    <= '0;
      wdata_q   <= 8'h00;
      di_q      <= 8'h00;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= is_wr;
        sel_q   <= map_sel;
        addr_q  <= map_addr;
        wdata_q <= z80_do;
      end
      // Mapper registers shadow the top of system RAM; the RAM write still happens.
      if (accept && is_wr && reg_hit) begin
        unique case (z80_addr[1:0])
          2'd0: cart_en_q <= z80_do[3];
          2'd1: bank0_q   <= ROM_BANK_W'(z80_do);
          2'd2: bank1_q   <= ROM_BANK_W'(z80_do);
          default: bank2_q <= ROM_BANK_W'(z80_do);
        endcase
      end
      if (state_q == S_REQ && mem_ack && !we_q) di_q <= mem_rdata;
    end
  end

  assign mem_req    = (state_q == S_REQ);
  assign mem_we     = we_q;
  assign mem_sel    = sel_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign z80_di     = di_q;
  assign z80_di_en  = acc && !we_q && (state_q == S_DONE);
  assign z80_wait_n = !(acc && state_q != S_DONE);

endmodule
